seg_scan_capture: RTL and testbench

- Receive side of the multiplexed 7-segment scan interface (sel/seg) driven by the digital-clock display scanner.
- Samples the scan stream, decodes each segment pattern back to a digit, and assembles one full 8-slot frame (HH-MM-SS).
- On each good frame, publishes binary hours/minutes/seconds and a valid pulse.
- Used for on-board readback and self-check of the display path; flags pattern, order and range errors.

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/seg_scan_capture_if.sv | 8 +
 rtl/seg7_decode.sv | 28 ++
 rtl/seg_scan_capture.sv | 151 +++++++++++++++
 tb/tb_seg_scan_capture.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan readback path: segment patterns,
// scan slot indices, capture states and the decoder result record.
package seg_pkg;

  localparam logic [7:0] SEG_0    = 8'h3f;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5b;
  localparam logic [7:0] SEG_3    = 8'h4f;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6d;
  localparam logic [7:0] SEG_6    = 8'h7d;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7f;
  localparam logic [7:0] SEG_9    = 8'h6f;
  localparam logic [7:0] SEG_DASH = 8'h40;

  localparam logic [2:0] SLOT_S1      = 3'd7;
  localparam logic [2:0] SLOT_S10     = 3'd6;
  localparam logic [2:0] SLOT_DASH_MS = 3'd5;
  localparam logic [2:0] SLOT_M1      = 3'd4;
  localparam logic [2:0] SLOT_M10     = 3'd3;
  localparam logic [2:0] SLOT_DASH_HM = 3'd2;
  localparam logic [2:0] SLOT_H1      = 3'd1;
  localparam logic [2:0] SLOT_H10     = 3'd0;

  typedef enum logic {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] digit;
    logic       is_dash;
    logic       valid;
  } dec_t;

  // 10*t + u using shifts only; 9*10+9 fits in 7 bits.
  function automatic logic [6:0] tens_units(input logic [3:0] t, input logic [3:0] u);
    return {t, 3'b000} + {2'b00, t, 1'b0} + {3'b000, u};
  endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Multiplexed 7-segment scan bus: digit select plus segment pattern.
interface seg_scan_capture_if;
  logic [2:0] sel;
  logic [7:0] seg;

  modport master (output sel, output seg);
  modport slave  (input  sel, input  seg);
endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder: digit 0..9, dash, or invalid.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [7:0] pattern,
  output dec_t       result
);

  always_comb begin
    result       = '0;
    result.valid = 1'b1;
    case (pattern)
      SEG_0:    result.digit = 4'd0;
      SEG_1:    result.digit = 4'd1;
      SEG_2:    result.digit = 4'd2;
      SEG_3:    result.digit = 4'd3;
      SEG_4:    result.digit = 4'd4;
      SEG_5:    result.digit = 4'd5;
      SEG_6:    result.digit = 4'd6;
      SEG_7:    result.digit = 4'd7;
      SEG_8:    result.digit = 4'd8;
      SEG_9:    result.digit = 4'd9;
      SEG_DASH: result.is_dash = 1'b1;
      default:  result.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the display scan bus: accepts stable slots, decodes them and
// assembles HH-MM-SS frames, publishing good frames and flagging bad ones.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned HOLD_MIN  = 1,
  parameter bit          DP_IGNORE = 1'b1
) (
  input  logic                      clk,
  input  logic                      res,
  seg_scan_capture_if.slave         scan,
  output logic [4:0]                hours,
  output logic [5:0]                minutes,
  output logic [5:0]                seconds,
  output logic                      frame_valid,
  output logic                      locked,
  output logic                      err_pattern,
  output logic                      err_order,
  output logic                      err_range
);

  localparam logic [3:0] HOLD = 4'(HOLD_MIN);

  state_t     state, state_n;
  logic [2:0] prev_sel;
  logic [3:0] cnt, cnt_n;
  logic       changed, accept;
  logic [2:0] expected, exp_n;
  logic [3:0] digs   [8];
  logic [3:0] digs_n [8];
  logic       locked_n, fv_n, ep_n, eo_n, er_n, upd;
  logic [6:0] h7, m7, s7;
  logic [7:0] pattern;
  dec_t       dec;
  logic       is_digit, dash_slot, slot_ok;

  assign changed = (scan.sel != prev_sel);

  always_comb begin
    if (changed)          cnt_n = 4'd1;
    else if (cnt >= HOLD) cnt_n = HOLD;
    else                  cnt_n = cnt + 4'd1;
  end

  // Saturation keeps cnt at HOLD for the rest of the run, so only the
  // arrival cycle (or a fresh change when HOLD is 1) accepts the slot.
  assign accept = (cnt_n == HOLD) && (changed || (cnt != HOLD));

  assign pattern = {(DP_IGNORE ? 1'b0 : scan.seg[7]), scan.seg[6:0]};

  seg7_decode u_decode (
    .pattern (pattern),
    .result  (dec)
  );

  assign is_digit  = dec.valid && !dec.is_dash;
  assign dash_slot = (scan.sel == SLOT_DASH_MS) || (scan.sel == SLOT_DASH_HM);
  assign slot_ok   = dec.valid && (dec.is_dash == dash_slot);

  always_comb begin
    state_n  = state;
    exp_n    = expected;
    digs_n   = digs;
    locked_n = locked;
    fv_n     = 1'b0;
    ep_n     = 1'b0;
    eo_n     = 1'b0;
    er_n     = 1'b0;
    upd      = 1'b0;
    h7       = tens_units(dec.digit, digs[SLOT_H1]);
    m7       = tens_units(digs[SLOT_M10], digs[SLOT_M1]);
    s7       = tens_units(digs[SLOT_S10], digs[SLOT_S1]);
    if (accept) begin
      case (state)
        HUNT: begin
          if (scan.sel == SLOT_S1 && is_digit) begin
            digs_n[SLOT_S1] = dec.digit;
            exp_n           = SLOT_S10;
            state_n         = CAPTURE;
          end
        end
        CAPTURE: begin
          if (scan.sel != expected) begin
            eo_n     = 1'b1;
            locked_n = 1'b0;
            // An out-of-order seconds-ones slot is itself a valid frame start.
            if (scan.sel == SLOT_S1 && is_digit) begin
              digs_n[SLOT_S1] = dec.digit;
              exp_n           = SLOT_S10;
            end else begin
              state_n = HUNT;
            end
          end else if (!slot_ok) begin
            ep_n     = 1'b1;
            locked_n = 1'b0;
            state_n  = HUNT;
          end else begin
            digs_n[scan.sel] = dec.digit;
            if (scan.sel == SLOT_H10) begin
              exp_n = SLOT_S1;
              if (h7 > 7'd23 || m7 > 7'd59 || s7 > 7'd59) begin
                er_n = 1'b1;
              end else begin
                upd      = 1'b1;
                fv_n     = 1'b1;
                locked_n = 1'b1;
              end
            end else begin
              exp_n = scan.sel - 3'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= HUNT;
      prev_sel    <= '0;
      cnt         <= '0;
      expected    <= SLOT_S1;
      digs        <= '{default: '0};
      hours       <= '0;
      minutes     <= '0;
      seconds     <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      err_pattern <= 1'b0;
      err_order   <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      state       <= state_n;
      prev_sel    <= scan.sel;
      cnt         <= cnt_n;
      expected    <= exp_n;
      digs        <= digs_n;
      frame_valid <= fv_n;
      locked      <= locked_n;
      err_pattern <= ep_n;
      err_order   <= eo_n;
      err_range   <= er_n;
      if (upd) begin
        hours   <= 5'(h7);
        minutes <= 6'(m7);
        seconds <= 6'(s7);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: three parameterisations share one scan stream and
// are compared every cycle against a slot-level reference model.
module tb_seg_scan_capture;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  seg_scan_capture_if if_a ();
  seg_scan_capture_if if_b ();
  seg_scan_capture_if if_c ();

  logic [4:0] hours   [3];
  logic [5:0] minutes [3];
  logic [5:0] seconds [3];
  logic       frame_valid [3];
  logic       locked      [3];
  logic       err_pattern [3];
  logic       err_order   [3];
  logic       err_range   [3];

  seg_scan_capture #(.HOLD_MIN(1), .DP_IGNORE(1'b1)) u_h1 (
    .clk(clk), .res(res), .scan(if_a),
    .hours(hours[0]), .minutes(minutes[0]), .seconds(seconds[0]),
    .frame_valid(frame_valid[0]), .locked(locked[0]),
    .err_pattern(err_pattern[0]), .err_order(err_order[0]), .err_range(err_range[0]));

  seg_scan_capture #(.HOLD_MIN(3), .DP_IGNORE(1'b1)) u_h3 (
    .clk(clk), .res(res), .scan(if_b),
    .hours(hours[1]), .minutes(minutes[1]), .seconds(seconds[1]),
    .frame_valid(frame_valid[1]), .locked(locked[1]),
    .err_pattern(err_pattern[1]), .err_order(err_order[1]), .err_range(err_range[1]));

  seg_scan_capture #(.HOLD_MIN(1), .DP_IGNORE(1'b0)) u_dp0 (
    .clk(clk), .res(res), .scan(if_c),
    .hours(hours[2]), .minutes(minutes[2]), .seconds(seconds[2]),
    .frame_valid(frame_valid[2]), .locked(locked[2]),
    .err_pattern(err_pattern[2]), .err_order(err_order[2]), .err_range(err_range[2]));

  int unsigned HOLD [3] = '{1, 3, 1};
  bit          DPI  [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0]  PAT  [10] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07, 8'h7f, 8'h6f};

  // Reference model state, one set per instance.
  bit m_hunt [3];
  int m_exp  [3];
  int m_dig  [3][8];
  bit m_locked [3];
  int m_h [3], m_m [3], m_s [3];
  bit m_fv [3], m_ep [3], m_eo [3], m_er [3];

  int checks = 0;
  int errors = 0;
  int last_sel = 0;

  function automatic int decode(logic [7:0] g, bit dp_ign);
    logic [7:0] p;
    p = dp_ign ? {1'b0, g[6:0]} : g;
    for (int i = 0; i < 10; i++) if (p == PAT[i]) return i;
    if (p == 8'h40) return 10;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_hunt[d] = 1'b1; m_exp[d] = 7; m_locked[d] = 1'b0;
      m_h[d] = 0; m_m[d] = 0; m_s[d] = 0;
      m_fv[d] = 0; m_ep[d] = 0; m_eo[d] = 0; m_er[d] = 0;
      for (int k = 0; k < 8; k++) m_dig[d][k] = 0;
    end
  endtask

  task automatic model_slot(int d, int s, logic [7:0] g);
    int v, hh, mm, ss;
    bit isdig, dslot;
    v = decode(g, DPI[d]);
    isdig = (v >= 0) && (v <= 9);
    dslot = (s == 5) || (s == 2);
    if (m_hunt[d]) begin
      if (s == 7 && isdig) begin m_dig[d][7] = v; m_exp[d] = 6; m_hunt[d] = 1'b0; end
    end else if (s != m_exp[d]) begin
      m_eo[d] = 1'b1; m_locked[d] = 1'b0;
      if (s == 7 && isdig) begin m_dig[d][7] = v; m_exp[d] = 6; end
      else m_hunt[d] = 1'b1;
    end else if (v < 0 || (dslot != (v == 10))) begin
      m_ep[d] = 1'b1; m_locked[d] = 1'b0; m_hunt[d] = 1'b1;
    end else begin
      m_dig[d][s] = v;
      if (s == 0) begin
        hh = m_dig[d][0] * 10 + m_dig[d][1];
        mm = m_dig[d][3] * 10 + m_dig[d][4];
        ss = m_dig[d][6] * 10 + m_dig[d][7];
        if (hh > 23 || mm > 59 || ss > 59) m_er[d] = 1'b1;
        else begin
          m_h[d] = hh; m_m[d] = mm; m_s[d] = ss;
          m_fv[d] = 1'b1; m_locked[d] = 1'b1;
        end
        m_exp[d] = 7;
      end else m_exp[d] = s - 1;
    end
  endtask

  task automatic check_all(string tag);
    logic [21:0] obs, exp_v;
    for (int d = 0; d < 3; d++) begin
      obs   = {hours[d], minutes[d], seconds[d], frame_valid[d], locked[d],
               err_pattern[d], err_order[d], err_range[d]};
      exp_v = {5'(m_h[d]), 6'(m_m[d]), 6'(m_s[d]), m_fv[d], m_locked[d],
               m_ep[d], m_eo[d], m_er[d]};
      checks++;
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp_v);
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(logic [2:0] s, logic [7:0] g, bit [2:0] acc, string tag);
    if_a.sel = s; if_a.seg = g;
    if_b.sel = s; if_b.seg = g;
    if_c.sel = s; if_c.seg = g;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin m_fv[d] = 0; m_ep[d] = 0; m_eo[d] = 0; m_er[d] = 0; end
    if (res) model_reset();
    else for (int d = 0; d < 3; d++) if (acc[d]) model_slot(d, int'(s), g);
    check_all(tag);
  endtask

  // A run of len cycles on one sel is accepted once, on its HOLD_MIN-th cycle.
  task automatic run(int s, logic [7:0] g, int len, string tag);
    bit [2:0] acc;
    for (int i = 1; i <= len; i++) begin
      for (int d = 0; d < 3; d++) acc[d] = (i == int'(HOLD[d]));
      tick(3'(s), g, acc, tag);
    end
    last_sel = s;
  endtask

  task automatic do_reset(int n);
    res = 1'b1;
    for (int i = 0; i < n; i++) tick(3'(last_sel), 8'h00, 3'b000, "reset");
    res = 1'b0;
  endtask

  // len 0 picks a random run length per slot; bad_slot >= 0 overrides that slot's pattern.
  task automatic frame(int h, int m, int s, int len, bit dp, int bad_slot,
                       logic [7:0] bad_pat, string tag);
    int dg [8];
    logic [7:0] g;
    int l;
    dg[7] = s % 10; dg[6] = s / 10; dg[5] = 10; dg[4] = m % 10;
    dg[3] = m / 10; dg[2] = 10; dg[1] = h % 10; dg[0] = h / 10;
    for (int k = 7; k >= 0; k--) begin
      g = (dg[k] == 10) ? 8'h40 : PAT[dg[k]];
      if (dp) g[7] = 1'b1;
      if (k == bad_slot) g = bad_pat;
      l = (len == 0) ? int'($urandom_range(1, 5)) : len;
      run(k, g, l, tag);
    end
  endtask

  initial begin
    int op, s;
    res = 1'b1;
    if_a.sel = '0; if_a.seg = '0;
    if_b.sel = '0; if_b.seg = '0;
    if_c.sel = '0; if_c.seg = '0;
    model_reset();
    do_reset(2);
    chk("reset_hours", int'(hours[0]), 0);
    chk("reset_locked", int'(locked[0]), 0);

    // Clean 12-34-56, one cycle per slot, starting mid-frame at sel 3.
    run(3, PAT[3], 1, "clean_start");
    run(2, 8'h40, 1, "clean_start");
    run(1, PAT[2], 1, "clean_start");
    run(0, PAT[1], 1, "clean_start");
    repeat (3) frame(12, 34, 56, 1, 1'b0, -1, 8'h00, "clean_h1");
    chk("h1_hours", int'(hours[0]), 12);
    chk("h1_minutes", int'(minutes[0]), 34);
    chk("h1_seconds", int'(seconds[0]), 56);
    chk("h1_locked", int'(locked[0]), 1);
    chk("h3_unlocked_fast_scan", int'(locked[1]), 0);

    // Same scan with each sel held four cycles.
    repeat (3) frame(12, 34, 56, 4, 1'b0, -1, 8'h00, "clean_h3");
    chk("h3_hours", int'(hours[1]), 12);
    chk("h3_locked", int'(locked[1]), 1);

    // Order error 7,6,5,3 then relock.
    run(7, PAT[8], 4, "order");
    run(6, PAT[1], 4, "order");
    run(5, 8'h40, 4, "order");
    run(3, PAT[2], 4, "order");
    chk("order_unlock", int'(locked[0]), 0);
    chk("order_hold_minutes", int'(minutes[0]), 34);
    frame(8, 22, 18, 4, 1'b0, -1, 8'h00, "relock");

    // Undecodable pattern on the minutes-ones slot, then recovery.
    frame(9, 9, 9, 4, 1'b0, 4, 8'h77, "pattern");
    frame(10, 11, 12, 4, 1'b0, -1, 8'h00, "pattern_recover");

    // Range error then a clean boundary frame.
    frame(25, 10, 0, 4, 1'b0, -1, 8'h00, "range");
    chk("range_hold_hours", int'(hours[0]), 10);
    chk("range_locked", int'(locked[0]), 1);
    frame(23, 59, 59, 4, 1'b0, -1, 8'h00, "range_max");
    chk("max_seconds", int'(seconds[1]), 59);

    // Reset mid-frame at sel 4; capture resumes only from sel 7.
    run(7, PAT[1], 4, "midreset");
    run(6, PAT[2], 4, "midreset");
    run(5, 8'h40, 4, "midreset");
    run(4, PAT[3], 4, "midreset");
    do_reset(1);
    chk("midreset_hours", int'(hours[0]), 0);
    run(3, PAT[4], 4, "post_reset");
    run(2, 8'h40, 4, "post_reset");
    run(1, PAT[5], 4, "post_reset");
    run(0, PAT[1], 4, "post_reset");
    chk("post_reset_no_lock", int'(locked[0]), 0);
    frame(13, 14, 15, 4, 1'b0, -1, 8'h00, "post_reset_frame");

    // Decimal point on a digit slot.
    frame(12, 34, 50, 4, 1'b0, 7, 8'hbf, "dp_slot");
    chk("dp_ignore_seconds", int'(seconds[0]), 50);
    chk("dp_strict_pattern_unlocked", int'(locked[2]), 0);
    frame(12, 34, 56, 4, 1'b1, -1, 8'h00, "dp_all");

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      op = int'($urandom_range(0, 99));
      if (op < 70) begin
        frame(int'($urandom_range(0, 29)), int'($urandom_range(0, 69)),
              int'($urandom_range(0, 69)), 0, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1,
              8'($urandom), "rand_frame");
      end else if (op < 95) begin
        do s = int'($urandom_range(0, 6)); while (s == last_sel);
        run(s, ($urandom_range(0, 1) == 1) ? PAT[$urandom_range(0, 9)] : 8'($urandom),
            int'($urandom_range(1, 5)), "rand_run");
      end else begin
        do_reset(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
